// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, operation
// selects and the MIPS funct codes that map onto them.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV  = 1'b1;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  function automatic logic is_mdu_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

  function automatic logic is_mf_funct(input logic [5:0] funct);
    return (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
  endfunction

  function automatic logic mdu_op_of(input logic [5:0] funct);
    return (funct == FUNCT_DIV) ? MDU_OP_DIV : MDU_OP_MULT;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control FSM (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic                    start;
  logic                    op;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    busy;
  logic                    done;
  logic                    div_zero;
  logic signed [WIDTH-1:0] hi;
  logic signed [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into the
// accumulator, then an arithmetic right shift of {acc, q, q_-1}.
module booth_step #(parameter int WIDTH = 32) (
  input  logic signed [WIDTH:0]   acc,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_m1,
  input  logic signed [WIDTH:0]   m,
  output logic signed [WIDTH:0]   acc_nx,
  output logic        [WIDTH-1:0] q_nx,
  output logic                    q_m1_nx
);
  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nx  = sum >>> 1;
    q_nx    = {sum[0], q[WIDTH-1:1]};
    q_m1_nx = q[0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes with a sign-fix cycle) producing HI/LO for MFHI/MFLO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave mdu
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mdu_state_e state, state_nx;
  logic [CNT_W-1:0] count;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_nx, done_nx;
  logic             accept;

  // MULT: acc/q/q_m1 form the Booth triple, m the sign-extended multiplicand.
  // DIV: acc is the partial remainder, q shifts the dividend out and the quotient in.
  logic signed [WIDTH:0]   acc, m;
  logic        [WIDTH-1:0] q;
  logic                    q_m1;
  logic                    neg_a, neg_b;

  logic signed [WIDTH:0]   acc_booth;
  logic        [WIDTH-1:0] q_booth;
  logic                    q_m1_booth;
  logic        [WIDTH:0]   div_shift;
  logic        [WIDTH+1:0] div_diff;

  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic s);
    return s ? -x : x;
  endfunction

  assign accept = (state == ST_IDLE) && mdu.start && !done_q;

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .acc     (acc),
    .q       (q),
    .q_m1    (q_m1),
    .m       (m),
    .acc_nx  (acc_booth),
    .q_nx    (q_booth),
    .q_m1_nx (q_m1_booth)
  );

  assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {1'b0, $unsigned(m)};

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Divide-by-zero passes through FIX as a one-cycle settle so done lands two edges after start.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) begin
        if (mdu.op == MDU_OP_MULT) state_nx = ST_MULT;
        else if (mdu.b == '0)      state_nx = ST_FIX;
        else                       state_nx = ST_DIV;
      end
      ST_MULT: if (count == LAST) state_nx = ST_DONE;
      ST_DIV:  if (count == LAST) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      count  <= '0;
    end else begin
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (accept) begin
        dz_q  <= (mdu.op == MDU_OP_DIV) && (mdu.b == '0);
        count <= '0;
      end else if (state == ST_MULT || state == ST_DIV) begin
        count <= count + CNT_W'(1);
      end
      if (state == ST_DONE && !dz_q) begin
        hi_q <= acc[WIDTH-1:0];
        lo_q <= q;
      end
    end
  end

  // Datapath registers carry no reset; every operation reinitialises them on accept.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: if (accept) begin
        neg_a <= mdu.a[WIDTH-1];
        neg_b <= mdu.b[WIDTH-1];
        q_m1  <= 1'b0;
        acc   <= '0;
        if (mdu.op == MDU_OP_MULT) begin
          q <= mdu.b;
          m <= {mdu.a[WIDTH-1], mdu.a};
        end else begin
          q <= abs_mag(mdu.a);
          m <= {1'b0, abs_mag(mdu.b)};
        end
      end
      ST_MULT: begin
        acc  <= acc_booth;
        q    <= q_booth;
        q_m1 <= q_m1_booth;
      end
      ST_DIV: begin
        if (div_diff[WIDTH+1]) acc <= div_shift;
        else                   acc <= div_diff[WIDTH:0];
        q <= {q[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end
      ST_FIX: begin
        acc <= {1'b0, neg_if(acc[WIDTH-1:0], neg_a)};
        q   <= neg_if(q, neg_a ^ neg_b);
      end
      default: ;
    endcase
  end

  assign mdu.busy     = busy_q;
  assign mdu.done     = done_q;
  assign mdu.div_zero = dz_q;
  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus random MULT/DIV
// traffic checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   prev_busy = 1'b0;
  bit   prev_done = 1'b0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  mult_div_unit_if #(.WIDTH(32)) mif();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Reference: exact signed product / truncating division from plain integer arithmetic.
  function automatic exp_t model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    exp_t   e;
    longint p;
    int     sa, sb;
    sa = a_i;
    sb = b_i;
    e.dz = 1'b0;
    e.due = 0;
    if (op_i == 1'b0) begin
      p = longint'(sa) * longint'(sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = 33;
    end else if (sb == 0) begin
      e.dz = 1'b1;
      e.hi = model_hi;
      e.lo = model_lo;
      e.lat = 2;
    end else if (a_i == 32'h8000_0000 && sb == -1) begin
      e.hi = 32'h0;
      e.lo = 32'h8000_0000;
      e.lat = 34;
    end else begin
      e.hi = sa % sb;
      e.lo = sa / sb;
      e.lat = 34;
    end
    model_hi = e.hi;
    model_lo = e.lo;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the unit reports done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (mif.done) begin
        chk("done_busy_low", {31'b0, mif.busy}, 32'h0);
        chk("done_one_cycle", {31'b0, prev_done}, 32'h0);
        chk("busy_before_done", {31'b0, prev_busy}, 32'h1);
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("hi", mif.hi, e.hi);
          chk("lo", mif.lo, e.lo);
          chk("div_zero", {31'b0, mif.div_zero}, {31'b0, e.dz});
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end
      prev_busy = mif.busy;
      prev_done = mif.done;
    end else begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((mif.busy || mif.done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("idle_timeout", 32'h1, 32'h0);
  endtask

  // Drives start for one edge; returns with cyc == N (the sampling edge).
  task automatic issue(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input bit push, output int n_edge);
    exp_t e;
    wait_idle();
    mif.start = 1'b1;
    mif.op    = op_i;
    mif.a     = a_i;
    mif.b     = b_i;
    n_edge    = cyc + 1;
    if (push) begin
      e = model(op_i, a_i, b_i);
      e.due = n_edge + e.lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    mif.start = 1'b0;
    mif.op    = 1'($urandom);
    mif.a     = $urandom;
    mif.b     = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'h0);
      sbq.delete();
    end
  endtask

  initial begin
    int n;
    int sel;
    logic op_r;
    logic [31:0] a_r, b_r;
    mif.start = 1'b0;
    mif.op    = 1'b0;
    mif.a     = '0;
    mif.b     = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, mif.busy}, 32'h0);
    chk("rst_done", {31'b0, mif.done}, 32'h0);
    chk("rst_div_zero", {31'b0, mif.div_zero}, 32'h0);
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    reset = 1'b1;

    // Test 1: MULT 7 * -3 with busy window
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, n);
    chk("t1_busy_first", {31'b0, mif.busy}, 32'h1);
    while (cyc < n + 32) @(negedge clk);
    chk("t1_busy_last", {31'b0, mif.busy}, 32'h1);
    chk("t1_done_not_yet", {31'b0, mif.done}, 32'h0);
    drain();

    // Test 2: largest positive squared
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, n);
    drain();

    // Test 3 and 4: signed divide, then divide by zero keeps hi/lo
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, n);
    drain();
    issue(1'b1, 32'd5, 32'd0, 1'b1, n);
    drain();
    repeat (3) @(negedge clk);
    chk("t4_div_zero_held", {31'b0, mif.div_zero}, 32'h1);

    // Test 5: start while busy is ignored
    issue(1'b0, 32'd3, 32'd4, 1'b1, n);
    chk("t5_div_zero_cleared", {31'b0, mif.div_zero}, 32'h0);
    while (cyc < n + 4) @(negedge clk);
    mif.start = 1'b1;
    mif.op    = 1'b1;
    mif.a     = 32'd9;
    mif.b     = 32'd0;
    @(negedge clk);
    mif.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("t5_no_extra_done", {31'b0, mif.done}, 32'h0);
    chk("t5_div_zero_still0", {31'b0, mif.div_zero}, 32'h0);

    // Test 6: reset during MULT iteration 10 aborts with outputs cleared
    issue(1'b0, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, n);
    while (cyc < n + 9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", {31'b0, mif.busy}, 32'h0);
    chk("t6_done", {31'b0, mif.done}, 32'h0);
    chk("t6_div_zero", {31'b0, mif.div_zero}, 32'h0);
    chk("t6_hi", mif.hi, 32'h0);
    chk("t6_lo", mif.lo, 32'h0);
    model_hi = '0;
    model_lo = '0;
    reset = 1'b1;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n);
    drain();

    // Random traffic with boundary operands mixed in
    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 7);
      op_r = 1'($urandom);
      a_r  = $urandom;
      b_r  = $urandom;
      case (sel)
        0: begin op_r = 1'b1; b_r = 32'h0; end
        1: begin a_r = 32'h8000_0000; b_r = 32'hFFFF_FFFF; end
        2: begin a_r = 32'($signed(8'($urandom))); b_r = 32'($signed(4'($urandom))); end
        3: a_r = 32'h8000_0000;
        default: ;
      endcase
      issue(op_r, a_r, b_r, 1'b1, n);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
